hdpldadapt_rx_datapath_lookahead: RTL and testbench

Two-word lookahead prefetch stage between the RX adapter FIFO read port and the 10GBASE-R insertion state machine. Issues FIFO reads on its own credit, holds up to three words, and presents the current word and the next word together so the insertion SM can inspect the next word for Idle/OS before consuming the current one. Also derives the empty and partially-empty status the insertion SM sees, and flags reads requested with nothing buffered.

---
 rtl/hdpldadapt_rx_datapath_lookahead.sv | 107 ++++++++++
 tb/tb_hdpldadapt_rx_datapath_lookahead.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/hdpldadapt_rx_datapath_lookahead.sv
// hdpldadapt_rx_datapath_lookahead
// Two-word lookahead prefetch between the RX adapter FIFO read port and the
// 10GBASE-R insertion state machine. Holds up to three words, issues FIFO
// reads against its own credit and presents current/next word side by side.
module hdpldadapt_rx_datapath_lookahead #(
   parameter int PCSDWIDTH = 64,
   parameter int PCSCWIDTH = 10
) (
   input  logic                           rd_clk,
   input  logic                           rd_rst_n,
   input  logic                           rd_srst_n,
   input  logic [PCSDWIDTH+PCSCWIDTH-1:0] fifo_rdata,
   input  logic                           fifo_empty,
   input  logic                           fifo_pempty,
   output logic                           fifo_rd_en,
   input  logic                           insert_sm_rd_en,
   output logic [PCSDWIDTH+PCSCWIDTH-1:0] baser_fifo_data,
   output logic [PCSDWIDTH+PCSCWIDTH-1:0] baser_fifo_data2,
   output logic                           rd_empty,
   output logic                           rd_pempty,
   output logic                           underflow,
   output logic [19:0]                    lookahead_testbus
);

   localparam int FDW = PCSDWIDTH + PCSCWIDTH;

   // Local-fault ordered set; every empty slot holds this word.
   localparam logic [FDW-1:0] FIFO_DEFAULT = FDW'({10'h011, 64'h0100009C_0100009C});

   logic [FDW-1:0] slot     [3];
   logic [FDW-1:0] slot_nxt [3];
   logic [1:0]     occ;
   logic [1:0]     occ_nxt;
   logic [1:0]     wr_idx;
   logic [2:0]     credit_used;
   logic           inflight;
   logic           adv;

   // Advance and read-credit decision: stored plus in-flight words never exceed three.
   always_comb begin
      adv         = insert_sm_rd_en && (occ != 2'd0);
      credit_used = {1'b0, occ} + {2'b00, inflight} - {2'b00, adv};
      fifo_rd_en  = !fifo_empty && (credit_used < 3'd3);
   end

   // Next slot contents: shift on advance first, then land the arriving word
   // in the first empty slot after the shift.
   always_comb begin
      for (int unsigned i = 0; i < 3; i++) begin
         slot_nxt[i] = slot[i];
      end
      if (adv) begin
         slot_nxt[0] = slot[1];
         slot_nxt[1] = slot[2];
         slot_nxt[2] = FIFO_DEFAULT;
      end
      wr_idx = occ - {1'b0, adv};
      if (inflight) begin
         case (wr_idx)
            2'd0:    slot_nxt[0] = fifo_rdata;
            2'd1:    slot_nxt[1] = fifo_rdata;
            2'd2:    slot_nxt[2] = fifo_rdata;
            default: ;
         endcase
      end
      occ_nxt = occ - {1'b0, adv} + {1'b0, inflight};
   end

   // State registers; synchronous reset has the same effect as the async one.
   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         for (int unsigned i = 0; i < 3; i++) begin
            slot[i] <= FIFO_DEFAULT;
         end
         occ       <= '0;
         inflight  <= 1'b0;
         underflow <= 1'b0;
      end else if (!rd_srst_n) begin
         for (int unsigned i = 0; i < 3; i++) begin
            slot[i] <= FIFO_DEFAULT;
         end
         occ       <= '0;
         inflight  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < 3; i++) begin
            slot[i] <= slot_nxt[i];
         end
         occ      <= occ_nxt;
         inflight <= fifo_rd_en;
         if (insert_sm_rd_en && (occ == 2'd0)) begin
            underflow <= 1'b1;
         end
      end
   end

   // Registered outputs straight from the slots, plus derived status.
   always_comb begin
      baser_fifo_data   = slot[0];
      baser_fifo_data2  = slot[1];
      rd_empty          = (occ == 2'd0);
      rd_pempty         = fifo_pempty || (occ < 2'd2);
      lookahead_testbus = {12'd0, underflow, inflight, occ, fifo_rd_en, adv,
                           rd_empty, rd_pempty};
   end

endmodule

// File: tb/tb_hdpldadapt_rx_datapath_lookahead.sv
// Testbench for hdpldadapt_rx_datapath_lookahead: a queue-based FIFO source
// and a queue-based model of the lookahead buffer.
module tb_hdpldadapt_rx_datapath_lookahead;

   localparam logic [73:0] DEF = {10'h011, 64'h0100009C_0100009C};

   logic        rd_clk;
   logic        rd_rst_n;
   logic        rd_srst_n;
   logic [73:0] fifo_rdata;
   logic        fifo_empty;
   logic        fifo_pempty;
   logic        fifo_rd_en;
   logic        insert_sm_rd_en;
   logic [73:0] baser_fifo_data;
   logic [73:0] baser_fifo_data2;
   logic        rd_empty;
   logic        rd_pempty;
   logic        underflow;
   logic [19:0] lookahead_testbus;

   hdpldadapt_rx_datapath_lookahead #(
      .PCSDWIDTH(64),
      .PCSCWIDTH(10)
   ) dut (
      .rd_clk            (rd_clk),
      .rd_rst_n          (rd_rst_n),
      .rd_srst_n         (rd_srst_n),
      .fifo_rdata        (fifo_rdata),
      .fifo_empty        (fifo_empty),
      .fifo_pempty       (fifo_pempty),
      .fifo_rd_en        (fifo_rd_en),
      .insert_sm_rd_en   (insert_sm_rd_en),
      .baser_fifo_data   (baser_fifo_data),
      .baser_fifo_data2  (baser_fifo_data2),
      .rd_empty          (rd_empty),
      .rd_pempty         (rd_pempty),
      .underflow         (underflow),
      .lookahead_testbus (lookahead_testbus)
   );

   initial rd_clk = 1'b0;
   always #5 rd_clk = ~rd_clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [73:0] fifo_q[$];   // upstream FIFO contents
   logic [73:0] mq[$];       // words the lookahead should be holding
   bit          m_inflight;
   bit          m_underflow;
   bit          src_hold;
   bit          chk_order;
   int          next_k;

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [73:0] mkword(input int k);
      return {10'(k), $urandom, 32'(k)};
   endfunction

   function automatic logic [73:0] garbage();
      return {10'($urandom), $urandom, $urandom};
   endfunction

   task automatic model_reset();
      mq.delete();
      m_inflight  = 1'b0;
      m_underflow = 1'b0;
   endtask

   // One clock: called at a falling edge with inputs set, returns at the next.
   task automatic step();
      int          sz;
      bit          req_now, adv_exp, en_exp, en_dut, rst_now;
      logic [73:0] rdata_now, e0, e1;
      logic [19:0] tb_exp;
      fifo_empty  = (fifo_q.size() == 0) || src_hold;
      fifo_pempty = (fifo_q.size() < 4);
      #1;
      sz      = mq.size();
      req_now = insert_sm_rd_en;
      adv_exp = req_now && (sz > 0);
      en_exp  = !fifo_empty && ((sz + int'(m_inflight) - int'(adv_exp)) < 3);
      e0      = (sz > 0) ? mq[0] : DEF;
      e1      = (sz > 1) ? mq[1] : DEF;
      tb_exp  = {12'd0, m_underflow, m_inflight, 2'(sz), en_exp, adv_exp,
                 sz == 0, fifo_pempty || (sz < 2)};
      chk("data",      baser_fifo_data,   e0);
      chk("data2",     baser_fifo_data2,  e1);
      chk("rd_empty",  rd_empty,          sz == 0);
      chk("rd_pempty", rd_pempty,         fifo_pempty || (sz < 2));
      chk("rd_en",     fifo_rd_en,        en_exp);
      chk("underflow", underflow,         m_underflow);
      chk("testbus",   lookahead_testbus, tb_exp);
      if (chk_order && req_now && (sz > 0)) begin
         chk("order", baser_fifo_data[31:0], next_k);
         next_k++;
      end
      rst_now   = rd_rst_n && rd_srst_n;
      en_dut    = fifo_rd_en;
      rdata_now = fifo_rdata;
      @(posedge rd_clk);
      if (!rst_now) begin
         model_reset();
      end else begin
         if (adv_exp) void'(mq.pop_front());
         if (m_inflight) mq.push_back(rdata_now);
         if (req_now && (sz == 0)) m_underflow = 1'b1;
         m_inflight = en_exp;
      end
      #1;
      if (en_dut && fifo_q.size() > 0) fifo_rdata = fifo_q.pop_front();
      else fifo_rdata = garbage();
      @(negedge rd_clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      rd_rst_n        = 1'b0;
      rd_srst_n       = 1'b1;
      insert_sm_rd_en = 1'b0;
      fifo_rdata      = '0;
      src_hold        = 1'b0;
      chk_order       = 1'b0;
      next_k          = 0;
      model_reset();
      @(negedge rd_clk);
      repeat (3) step();
      chk("rst_data",  baser_fifo_data, DEF);
      chk("rst_empty", rd_empty, 1'b1);
      rd_rst_n = 1'b1;
      step();

      // Fill with no advance: three reads, then credit exhausted.
      for (int k = 0; k < 4; k++) fifo_q.push_back(mkword(k));
      repeat (8) step();
      chk("fill_occ",       lookahead_testbus[5:4], 2'd3);
      chk("fill_fifo_left", fifo_q.size(), 1);
      chk("fill_rd_en",     fifo_rd_en, 1'b0);
      chk("fill_d0_k",      baser_fifo_data[31:0], 0);
      chk("fill_d1_k",      baser_fifo_data2[31:0], 1);

      // Continuous stream W0..W99 with advance held.
      for (int k = 4; k < 100; k++) fifo_q.push_back(mkword(k));
      chk_order       = 1'b1;
      insert_sm_rd_en = 1'b1;
      repeat (110) step();
      chk_order = 1'b0;
      chk("order_count", next_k, 100);

      // Single word then empty, advance held; ends in underflow.
      fifo_q.push_back(mkword(200));
      repeat (6) step();
      chk("uf_set",   underflow, 1'b1);
      chk("uf_empty", rd_empty, 1'b1);
      insert_sm_rd_en = 1'b0;
      repeat (2) step();
      chk("uf_sticky", underflow, 1'b1);
      rd_srst_n = 1'b0;
      step();
      rd_srst_n = 1'b1;
      step();
      chk("uf_clr", underflow, 1'b0);

      // Async reset mid-fill while a read is in flight.
      for (int k = 300; k < 306; k++) fifo_q.push_back(mkword(k));
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         if (lookahead_testbus[5:4] == 2'd2 && lookahead_testbus[6]) found = 1'b1;
         else step();
      end
      chk("arst_setup", found, 1'b1);
      rd_rst_n = 1'b0;
      #1;
      chk("arst_data",   baser_fifo_data, DEF);
      chk("arst_data2",  baser_fifo_data2, DEF);
      chk("arst_empty",  rd_empty, 1'b1);
      chk("arst_pempty", rd_pempty, 1'b1);
      chk("arst_tbus",   lookahead_testbus[6:4], 3'd0);
      model_reset();
      repeat (2) step();
      rd_rst_n = 1'b1;
      fifo_q.delete();
      for (int k = 400; k < 406; k++) fifo_q.push_back(mkword(k));
      repeat (10) step();

      // Randomised traffic.
      for (int c = 0; c < 1500; c++) begin
         insert_sm_rd_en = ($urandom % 4) != 0;
         src_hold        = ($urandom % 5) == 0;
         if (fifo_q.size() < 6 && ($urandom % 3) != 0) fifo_q.push_back(mkword(1000 + c));
         rd_srst_n = ($urandom % 200) != 0;
         step();
      end
      rd_srst_n = 1'b1;
      src_hold  = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
